// File: rtl/ps2_pkg.sv
// Shared PS/2 command codes and transmitter state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_REQ,
    TX_SEND,
    TX_ACK,
    TX_WAIT_IDLE,
    TX_DONE
  } tx_state_t;

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for a raw PS/2 pin plus a falling-edge strobe.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta;
  logic prev;

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= pin;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall = prev & ~level;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 byte transmitter with open-drain drive-low enables.
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps_clk_in,
  input  logic       ps_data_in,
  input  logic [7:0] code_in,
  input  logic       code_valid_in,
  output logic       ready_out,
  output logic       busy_out,
  output logic       ps_clk_drive_low_out,
  output logic       ps_data_drive_low_out,
  output logic       done_out,
  output logic       error_out
);

  localparam int CW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  tx_state_t   state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [3:0]  bit_idx;
  logic [7:0]  code_q;
  logic        parity;
  logic        ack_err;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic unused_data_fall;

  ps2_sync u_clk_sync (
    .clk   (clk_in),
    .rst   (rst_in),
    .pin   (ps_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync u_data_sync (
    .clk   (clk_in),
    .rst   (rst_in),
    .pin   (ps_data_in),
    .level (data_level),
    .fall  (unused_data_fall)
  );

  logic on_wire;
  assign on_wire = (state == TX_REQ) || (state == TX_SEND) ||
                   (state == TX_ACK) || (state == TX_WAIT_IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                 <= TX_IDLE;
      ready_out             <= 1'b1;
      busy_out              <= 1'b0;
      ps_clk_drive_low_out  <= 1'b0;
      ps_data_drive_low_out <= 1'b0;
      done_out              <= 1'b0;
      error_out             <= 1'b0;
      cnt                   <= '0;
      tmo                   <= '0;
      bit_idx               <= '0;
      code_q                <= '0;
      parity                <= 1'b0;
      ack_err               <= 1'b0;
    end else begin
      done_out <= 1'b0;
      unique case (state)
        TX_IDLE: begin
          if (code_valid_in) begin
            code_q               <= code_in;
            parity               <= ~^code_in;
            cnt                  <= '0;
            ready_out            <= 1'b0;
            busy_out             <= 1'b1;
            error_out            <= 1'b0;
            ps_clk_drive_low_out <= 1'b1;
            state                <= TX_INHIBIT;
          end
        end
        TX_INHIBIT: begin
          if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
            ps_data_drive_low_out <= 1'b1;
            tmo                   <= '0;
            state                 <= TX_REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_REQ: begin
          ps_clk_drive_low_out  <= 1'b0;
          ps_data_drive_low_out <= 1'b1;
          bit_idx               <= '0;
          ack_err               <= 1'b0;
          state                 <= TX_SEND;
        end
        TX_SEND: begin
          if (clk_fall) begin
            if (bit_idx < 4'd8)
              ps_data_drive_low_out <= ~code_q[bit_idx[2:0]];
            else if (bit_idx == 4'd8)
              ps_data_drive_low_out <= ~parity;
            else
              ps_data_drive_low_out <= 1'b0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 4'd9)
              state <= TX_ACK;
          end
        end
        TX_ACK: begin
          if (clk_fall) begin
            ack_err <= data_level;
            state   <= TX_WAIT_IDLE;
          end
        end
        TX_WAIT_IDLE: begin
          if (clk_level && data_level) begin
            done_out  <= 1'b1;
            error_out <= ack_err;
            state     <= TX_DONE;
          end
        end
        TX_DONE: begin
          ready_out <= 1'b1;
          busy_out  <= 1'b0;
          state     <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase

      // Later assignments override the state actions: timeout wins.
      if (on_wire) begin
        tmo <= tmo + 1'b1;
        if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          ps_clk_drive_low_out  <= 1'b0;
          ps_data_drive_low_out <= 1'b0;
          error_out             <= 1'b1;
          done_out              <= 1'b1;
          state                 <= TX_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Scoreboard bench for ps2_transmitter with a clocking PS/2 device model.
module tb_ps2_transmitter;

  localparam int INH = 8;
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps_clk;
  logic       ps_data;
  logic [7:0] code;
  logic       code_valid;
  logic       ready;
  logic       busy;
  logic       cdl;
  logic       ddl;
  logic       done;
  logic       error;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  always #5 clk = ~clk;

  assign ps_clk  = ~(cdl | dev_clk_low);
  assign ps_data = ~(ddl | dev_data_low);

  ps2_transmitter #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in                (clk),
    .rst_in                (rst),
    .ps_clk_in             (ps_clk),
    .ps_data_in            (ps_data),
    .code_in               (code),
    .code_valid_in         (code_valid),
    .ready_out             (ready),
    .busy_out              (busy),
    .ps_clk_drive_low_out  (cdl),
    .ps_data_drive_low_out (ddl),
    .done_out              (done),
    .error_out             (error)
  );

  typedef struct {
    logic        err;
    logic        chk_frame;
    logic [10:0] frame;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_cyc = 0;
  bit prev_both = 1'b0;

  bit model_en   = 1'b1;
  bit model_ack  = 1'b1;
  bit model_busy = 1'b0;
  int pulses     = 0;
  logic [10:0] frame_cap = '0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done_out pulse.
  always @(negedge clk) begin
    cyc++;
    if (cdl && ddl && !prev_both) req_cyc = cyc;
    prev_both = cdl && ddl;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("error_out", int'(error), int'(e.err));
        check("clk_released", int'(cdl), 0);
        check("data_released", int'(ddl), 0);
        if (e.chk_frame)
          check("wire_frame", int'(frame_cap), int'(e.frame));
        if (e.lat >= 0)
          check("timeout_latency", cyc - req_cyc, e.lat);
      end
    end
  end

  // Device model: clocks 11 pulses at a 20-cycle period once a request is seen.
  task automatic run_frame();
    logic [10:0] cap;
    cap = '0;
    model_busy = 1'b1;
    pulses = 0;
    repeat (4) @(negedge clk);
    cap[0] = ps_data;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        dev_data_low = model_ack;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clk);
      if (k <= 10) cap[k] = ps_data;
      if (k == 10) frame_cap = cap;
      dev_clk_low = 1'b0;
      pulses = k;
      repeat (10) @(negedge clk);
    end
    dev_data_low = 1'b0;
    model_busy = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (model_en && !model_busy && !cdl && ddl)
        run_frame();
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ready && sb.size() == 0 && !model_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_in_budget", int'(n < 2000), 1);
  endtask

  task automatic send(input logic [7:0] c, input exp_t x);
    wait_idle();
    sb.push_back(x);
    code = c;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    wait_idle();
  endtask

  function automatic exp_t mk(input logic err, input logic chk,
                              input logic [10:0] fr, input int lat);
    exp_t r;
    r.err = err;
    r.chk_frame = chk;
    r.frame = fr;
    r.lat = lat;
    return r;
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    code = 8'h00;
    code_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_clk_dl", int'(cdl), 0);
    check("rst_data_dl", int'(ddl), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frames are {stop, parity, d7..d0, start}.
    send(8'hED, mk(1'b0, 1'b1, 11'b1_1_11101101_0, -1));
    send(8'h00, mk(1'b0, 1'b1, 11'b1_1_00000000_0, -1));
    send(8'h01, mk(1'b0, 1'b1, 11'b1_0_00000001_0, -1));

    model_ack = 1'b0;
    send(8'hED, mk(1'b1, 1'b1, 11'b1_1_11101101_0, -1));
    model_ack = 1'b1;
    check("error_holds", int'(error), 1);

    model_en = 1'b0;
    send(8'hFF, mk(1'b1, 1'b0, 11'b0, TMO));
    model_en = 1'b1;

    // Request held across the frame with a different byte.
    wait_idle();
    sb.push_back(mk(1'b0, 1'b1, 11'b1_1_11101101_0, -1));
    code = 8'hED;
    code_valid = 1'b1;
    @(negedge clk);
    code = 8'h55;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("held_done_in_budget", int'(n < 2000), 1);
    code_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("held_not_requeued", int'(busy), 0);
    wait_idle();

    // Reset in the middle of the data bits.
    code = 8'hED;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    n = 0;
    while (pulses < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_send_reached", int'(n < 2000), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_clk_dl", int'(cdl), 0);
    check("rst_mid_data_dl", int'(ddl), 0);
    check("rst_mid_ready", int'(ready), 1);
    check("rst_mid_done", int'(done), 0);
    rst = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
